// File: rtl/operand_pkg.sv
// Shared types and helpers for the operand loader.
//   state_e : loader FSM states
//   OP_*    : default geometry (32-bit elements, 64-bit row beats)
//   elem()  : slice element k out of a default-width row beat
package operand_pkg;

    localparam int unsigned OP_DATA_WIDTH = 32;
    localparam int unsigned OP_BUS_WIDTH  = 64;
    localparam int unsigned OP_MAX_DIM    = OP_BUS_WIDTH / OP_DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitRow = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } state_e;

    function automatic logic [OP_DATA_WIDTH-1:0] elem(
        input logic [OP_BUS_WIDTH-1:0] row,
        input int unsigned             k
    );
        return row[k*OP_DATA_WIDTH +: OP_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/operand_row_unpacker.sv
// Row capture register with a column-indexed element mux.
//   clk, rst_n : clock, synchronous active-low reset (clears the buffer)
//   load       : capture row_data this cycle
//   row_data   : incoming row beat, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   col        : element index into the captured row
//   elem       : selected element of the captured row
module operand_row_unpacker
    import operand_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OP_DATA_WIDTH,
    parameter int unsigned BUS_WIDTH  = OP_BUS_WIDTH,
    parameter int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BUS_WIDTH-1:0]  row_data,
    input  logic [CNT_WIDTH-1:0]  col,
    output logic [DATA_WIDTH-1:0] elem
);

    logic [BUS_WIDTH-1:0]  buf_q;
    logic [DATA_WIDTH-1:0] elems [MAX_DIM];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= row_data;
        end
    end

    for (genvar k = 0; k < MAX_DIM; k++) begin : g_elems
        assign elems[k] = buf_q[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign elem = elems[col];

endmodule

// File: rtl/operand_loader.sv
// Write-side initiator for the operand register file. Accepts MAX_DIM row
// beats over valid/ready and writes each row out one element per cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : begin loading a full MAX_DIM x MAX_DIM matrix (idle only)
//   row_data_i    : row beat, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   row_valid_i   : row beat valid
//   row_ready_o   : loader waiting for a row
//   mem_we_o      : register file write enable
//   mem_addr_o    : register file write address
//   mem_wdata_o   : register file write data
//   busy_o        : load in progress
//   done_o        : one-cycle pulse after the last element is written
module operand_loader
    import operand_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = OP_DATA_WIDTH,
    parameter int unsigned          BUS_WIDTH  = OP_BUS_WIDTH,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [BUS_WIDTH-1:0]  row_data_i,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CntW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(MAX_DIM - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] row_q, row_d;
    logic [CntW-1:0] col_q, col_d;
    logic            load;
    logic [DATA_WIDTH-1:0] cur_elem;

    operand_row_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .CNT_WIDTH  (CntW)
    ) u_unpacker (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (load),
        .row_data (row_data_i),
        .col      (col_q),
        .elem     (cur_elem)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state: the handshake is qualified by state only, so row_valid_i
    // and row_data_i have no effect outside StWaitRow.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWaitRow;
                    row_d   = '0;
                end
            end
            StWaitRow: begin
                if (row_valid_i) begin
                    load    = 1'b1;
                    col_d   = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (col_q == LastIdx) begin
                    col_d = '0;
                    if (row_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = StWaitRow;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode purely from registered state; address wraps in ADDR_WIDTH.
    always_comb begin
        row_ready_o = (state_q == StWaitRow);
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == StWrite) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = BASE_ADDR
                        + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(MAX_DIM)
                        + ADDR_WIDTH'(col_q);
            mem_wdata_o = cur_elem;
        end
    end

endmodule
